// File: rtl/rr_load_arbiter_pkg.sv
// Shared definitions for the round-robin load arbiter: FSM state codes
// and a width helper used for the owner index and the hold counter.
package rr_load_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Bits needed to hold the values 0..n-1, never less than one bit
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_load_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so the
// priority pointer lands on bit 0, finds the lowest set bit, then maps
// that position back to an absolute requester index.
module rr_pick
    import rr_load_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   winner
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       sum;

    // Rotate, priority-encode from the pointer position, then un-rotate
    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[NUM_REQ-1:0];
        any     = |req;
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        sum = {1'b0, offset} + {1'b0, ptr};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/rr_load_arbiter.sv
// Round-robin controller owning the load enable of one shared register.
// A granted requester's data is captured, then the register is held for
// HOLD_CYCLES cycles before the next arbitration round.
module rr_load_arbiter
    import rr_load_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset_al_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [NUM_REQ*WIDTH-1:0]   data_in,
    output logic [NUM_REQ-1:0]         grant_out,
    output logic                       load_en_out,
    output logic [WIDTH-1:0]           q_out,
    output logic [clog2(NUM_REQ)-1:0]  owner_out,
    output logic                       busy_out
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(HOLD_CYCLES);

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               load_en_q, load_en_d;
    logic               busy_q, busy_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_winner;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (req_in),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Next-state logic: grant in IDLE, count down the hold window in HOLD
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        grant_d   = '0;
        load_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    data_d    = data_in[int'(pick_winner)*WIDTH +: WIDTH];
                    owner_d   = pick_winner;
                    grant_d   = NUM_REQ'(1) << pick_winner;
                    load_en_d = 1'b1;
                    if (pick_winner == IDX_W'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = pick_winner + 1'b1;
                    end
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = ST_HOLD;
                    busy_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately by the active-low reset
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            data_q    <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            load_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            load_en_q <= load_en_d;
            busy_q    <= busy_d;
        end
    end

    assign grant_out   = grant_q;
    assign load_en_out = load_en_q;
    assign q_out       = data_q;
    assign owner_out   = owner_q;
    assign busy_out    = busy_q;

endmodule

// File: tb/tb_rr_load_arbiter.sv
// Scoreboard bench for rr_load_arbiter: stimulus pushes the expected grant
// (winner, data, cycle) and a monitor pops and compares on every grant.
module tb_rr_load_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int WIDTH       = 8;
    localparam int HOLD_CYCLES = 2;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] q;
        logic [1:0] owner;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_al_in;
    logic [3:0]  req_in;
    logic [31:0] data_in;
    logic [3:0]  grant_out;
    logic        load_en_out;
    logic [7:0]  q_out;
    logic [1:0]  owner_out;
    logic        busy_out;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    rr_load_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .req_in      (req_in),
        .data_in     (data_in),
        .grant_out   (grant_out),
        .load_en_out (load_en_out),
        .q_out       (q_out),
        .owner_out   (owner_out),
        .busy_out    (busy_out)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp expected grants
    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        data_in[idx*8 +: 8] = val;
    endtask

    task automatic push_exp(input int idx, input logic [7:0] d, input int at_cyc);
        exp_t e;
        e.grant = 4'b0001 << idx;
        e.q     = d;
        e.owner = 2'(idx);
        e.cyc   = at_cyc;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [3:0] req);
        req_in = req;
    endtask

    // Monitor: one-hot and load/grant consistency each cycle, scoreboard on grants
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check_output("grant_onehot", ($countones(grant_out) <= 1), 1);
            check_output("load_vs_grant", load_en_out, (grant_out != 4'b0));
            if (grant_out != 4'b0) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_grant", grant_out, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("sb_grant", grant_out, e.grant);
                    check_output("sb_q", q_out, e.q);
                    check_output("sb_owner", owner_out, e.owner);
                    check_output("sb_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        reset_al_in = 1'b0;
        req_in      = 4'b0;
        data_in     = 32'b0;
        repeat (2) @(negedge clk);
        check_output("rst_q", q_out, 0);
        check_output("rst_grant", grant_out, 0);
        check_output("rst_load", load_en_out, 0);
        check_output("rst_owner", owner_out, 0);
        check_output("rst_busy", busy_out, 0);
        reset_al_in = 1'b1;
        @(negedge clk);

        // Simultaneous requests right after reset: pointer 0 picks requester 1
        set_data(1, 8'h11);
        set_data(2, 8'h22);
        apply_stimulus(4'b0110);
        push_exp(1, 8'h11, cyc + 1);
        @(negedge clk);
        apply_stimulus(4'b0000);
        check_output("sim_busy", busy_out, 1);
        check_output("sim_owner", owner_out, 1);
        @(negedge clk);
        check_output("sim_busy_hold", busy_out, 1);
        @(negedge clk);
        check_output("sim_idle", busy_out, 0);

        // Single request from requester 2
        set_data(2, 8'h3C);
        apply_stimulus(4'b0100);
        push_exp(2, 8'h3C, cyc + 1);
        @(negedge clk);
        apply_stimulus(4'b0000);
        check_output("single_grant", grant_out, 4'b0100);
        check_output("single_load", load_en_out, 1);
        check_output("single_q", q_out, 8'h3C);
        check_output("single_owner", owner_out, 2);
        check_output("single_busy", busy_out, 1);
        @(negedge clk);
        check_output("single_busy2", busy_out, 1);
        check_output("single_pulse", grant_out, 0);
        @(negedge clk);
        check_output("single_idle", busy_out, 0);

        // Wrap-around: grant 3, then 0 beats 3, then 3 alone
        set_data(3, 8'h77);
        apply_stimulus(4'b1000);
        push_exp(3, 8'h77, cyc + 1);
        @(negedge clk);
        apply_stimulus(4'b0000);
        repeat (2) @(negedge clk);
        set_data(0, 8'h50);
        apply_stimulus(4'b1001);
        push_exp(0, 8'h50, cyc + 1);
        @(negedge clk);
        apply_stimulus(4'b1000);
        check_output("wrap_owner0", owner_out, 0);
        repeat (2) @(negedge clk);
        set_data(3, 8'h78);
        push_exp(3, 8'h78, cyc + 1);
        @(negedge clk);
        apply_stimulus(4'b0000);
        check_output("wrap_owner3", owner_out, 3);
        repeat (2) @(negedge clk);

        // HOLD ignores new requests and data changes
        set_data(0, 8'h5A);
        apply_stimulus(4'b0001);
        push_exp(0, 8'h5A, cyc + 1);
        @(negedge clk);
        apply_stimulus(4'b0010);
        set_data(1, 8'h99);
        set_data(0, 8'hFF);
        push_exp(1, 8'h99, cyc + 3);
        @(negedge clk);
        check_output("hold_q", q_out, 8'h5A);
        check_output("hold_nogrant", grant_out, 0);
        @(negedge clk);
        check_output("hold_q2", q_out, 8'h5A);
        check_output("hold_idle", busy_out, 0);
        @(negedge clk);
        apply_stimulus(4'b0000);
        check_output("hold_after_owner", owner_out, 1);
        check_output("hold_after_q", q_out, 8'h99);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of HOLD
        set_data(2, 8'hA5);
        apply_stimulus(4'b0100);
        push_exp(2, 8'hA5, cyc + 1);
        @(negedge clk);
        apply_stimulus(4'b0000);
        check_output("pre_rst_q", q_out, 8'hA5);
        check_output("pre_rst_busy", busy_out, 1);
        #2 reset_al_in = 1'b0;
        #1;
        check_output("async_q", q_out, 0);
        check_output("async_busy", busy_out, 0);
        check_output("async_grant", grant_out, 0);
        check_output("async_owner", owner_out, 0);
        repeat (2) @(negedge clk);
        reset_al_in = 1'b1;

        // Fairness with all four requesting continuously
        set_data(0, 8'h10);
        set_data(1, 8'h20);
        set_data(2, 8'h30);
        set_data(3, 8'h40);
        apply_stimulus(4'b1111);
        for (int i = 0; i < 5; i++) begin
            push_exp(i % 4, 8'h10 * 8'((i % 4) + 1), cyc + 1 + 3 * i);
        end
        repeat (13) @(negedge clk);
        apply_stimulus(4'b0000);
        check_output("fair_last_owner", owner_out, 0);
        check_output("fair_last_q", q_out, 8'h10);
        repeat (4) @(negedge clk);
        check_output("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
